// File: rtl/mc_pkg.sv
// Shared definitions for the multicast tag scheduler: FSM state encoding,
// default field widths and the counter-width helper.
package mc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_RUN   = 3'd3,
        ST_DRAIN = 3'd4
    } state_e;

    localparam int DEF_ID_LEN    = 4;
    localparam int DEF_VALUE_LEN = 32;

    // One spare bit over the index width so the counter can hold NUM_PE itself
    function automatic int cnt_w(input int num_pe);
        return $clog2(num_pe) + 1;
    endfunction

endpackage

// File: rtl/mc_id_buf.sv
// ID staging buffer: NUM_PE x ID_LEN register file with one write port
// (filled while loading IDs) and one combinational read port (indexed
// while shifting). Storage has no reset; contents are always rewritten
// in full before they are read.
module mc_id_buf
    import mc_pkg::*;
#(
    parameter int ID_LEN = DEF_ID_LEN,
    parameter int NUM_PE = 8,
    parameter int AW     = $clog2(NUM_PE)
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [ID_LEN-1:0] wr_data_i,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [ID_LEN-1:0] rd_data_o
);

    logic [ID_LEN-1:0] mem_q [NUM_PE];

    // Capture each accepted ID word at its slot
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/mc_tag_scheduler.sv
// Multicast bus sequencer: loads NUM_PE controller IDs into the scan
// chain, then forwards tagged packets through a one-entry hold register
// onto the bus. Optional perf counters are built when
// MC_TAG_SCHED_PERF_EN is defined.
module mc_tag_scheduler
    import mc_pkg::*;
#(
    parameter int ID_LEN    = DEF_ID_LEN,
    parameter int VALUE_LEN = DEF_VALUE_LEN,
    parameter int NUM_PE    = 8
`ifdef MC_TAG_SCHED_PERF_EN
    ,
    parameter int PERF_W    = 16
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_start,
    input  logic                 cfg_valid,
    input  logic [ID_LEN-1:0]    cfg_id,
    output logic                 cfg_ready,
    output logic                 cfg_done,
    output logic                 set_id,
    output logic [ID_LEN-1:0]    id_out,
    input  logic                 in_valid,
    input  logic [ID_LEN-1:0]    in_tag,
    input  logic [VALUE_LEN-1:0] in_value,
    output logic                 in_ready,
    output logic [ID_LEN-1:0]    bus_tag,
    output logic                 bus_enable,
    output logic [VALUE_LEN-1:0] bus_value,
    input  logic                 bus_ready,
    output logic                 busy
`ifdef MC_TAG_SCHED_PERF_EN
    ,
    output logic [PERF_W-1:0]    perf_xfer,
    output logic [PERF_W-1:0]    perf_stall
`endif
);

    localparam int              CNT_W = cnt_w(NUM_PE);
    localparam int              AW    = $clog2(NUM_PE);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_PE - 1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic                  hold_v_q, hold_v_d;
    logic [ID_LEN-1:0]     hold_tag_q;
    logic [VALUE_LEN-1:0]  hold_val_q;
    logic                  accept;
    logic                  buf_we;
    logic [ID_LEN-1:0]     buf_rd;

    // Shift cycle k reads the far end first so PE j finishes holding word j
    mc_id_buf #(
        .ID_LEN (ID_LEN),
        .NUM_PE (NUM_PE),
        .AW     (AW)
    ) u_id_buf (
        .clk       (clk),
        .wr_en_i   (buf_we),
        .wr_addr_i (cnt_q[AW-1:0]),
        .wr_data_i (cfg_id),
        .rd_addr_i (AW'(LAST - cnt_q)),
        .rd_data_o (buf_rd)
    );

    assign cfg_ready  = (state_q == ST_LOAD);
    assign buf_we     = cfg_valid && cfg_ready;
    assign set_id     = (state_q == ST_SHIFT);
    assign id_out     = set_id ? buf_rd : '0;
    assign cfg_done   = done_q;
    assign busy       = (state_q != ST_IDLE) && (state_q != ST_RUN);

    assign in_ready   = (state_q == ST_RUN) && (!hold_v_q || bus_ready);
    assign accept     = in_valid && in_ready;
    assign hold_v_d   = accept || (hold_v_q && !bus_ready);

    assign bus_enable = hold_v_q;
    assign bus_tag    = hold_v_q ? hold_tag_q : '0;
    assign bus_value  = hold_v_q ? hold_val_q : '0;

    // Next-state logic for configuration sequencing and drain handling
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
            end
            ST_LOAD: begin
                if (cfg_valid) begin
                    if (cnt_q == LAST) begin
                        state_d = ST_SHIFT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_SHIFT: begin
                if (cnt_q == LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (cfg_start) begin
                    state_d = hold_v_d ? ST_DRAIN : ST_LOAD;
                    cnt_d   = '0;
                end
            end
            ST_DRAIN: begin
                if (!hold_v_d) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and completion-pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // One-entry hold register; payload only moves on an accept so it stays stable while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_v_q   <= 1'b0;
            hold_tag_q <= '0;
            hold_val_q <= '0;
        end else begin
            hold_v_q <= hold_v_d;
            if (accept) begin
                hold_tag_q <= in_tag;
                hold_val_q <= in_value;
            end
        end
    end

`ifdef MC_TAG_SCHED_PERF_EN
    logic [PERF_W-1:0] perf_xfer_q, perf_stall_q;
    logic              load_entry;

    assign load_entry = (state_d == ST_LOAD) && (state_q != ST_LOAD);

    // Saturating transfer/stall counters, cleared whenever reconfiguration begins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_xfer_q  <= '0;
            perf_stall_q <= '0;
        end else if (load_entry) begin
            perf_xfer_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if (hold_v_q && bus_ready && !(&perf_xfer_q)) begin
                perf_xfer_q <= perf_xfer_q + PERF_W'(1);
            end
            if (hold_v_q && !bus_ready && !(&perf_stall_q)) begin
                perf_stall_q <= perf_stall_q + PERF_W'(1);
            end
        end
    end

    assign perf_xfer  = perf_xfer_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule
